// File: rtl/instr_loader.sv
// instr_loader: serial valid/ready feeder that packs 32-bit words into
// the flat instruction bundle, pulses start once, then holds until reload.
//
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : word handshake; accept when both are high
//   in_word, in_last  : instruction word and end-of-program marker
//   reload            : discard bundle and return to loading
//   instr             : packed bundle, word 0 in the top slot
//   start             : one-cycle pulse when the bundle becomes valid
//   load_done         : high while the CPU runs the bundle
//   word_count        : words accepted since last reset/reload
module instr_loader #(
  parameter int NUM_WORDS = 10,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_word,
  input  logic                        in_last,
  output logic                        in_ready,
  input  logic                        reload,
  output logic [NUM_WORDS*WORD_W-1:0] instr,
  output logic                        start,
  output logic                        load_done,
  output logic [CNT_W-1:0]            word_count
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(NUM_WORDS - 1);

  state_t state;
  logic   accept;
  logic   at_last_slot;
  logic   finish;

  assign in_ready     = (state == LOAD) && !reload;
  assign accept       = in_valid && in_ready;
  assign at_last_slot = (word_count == LAST_IDX);
  // Auto-fire on the final slot so word_count never passes NUM_WORDS.
  assign finish       = in_last || at_last_slot;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOAD;
      instr      <= '0;
      word_count <= '0;
      start      <= 1'b0;
      load_done  <= 1'b0;
    end else if (reload) begin
      state      <= LOAD;
      instr      <= '0;
      word_count <= '0;
      start      <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          start     <= 1'b0;
          load_done <= 1'b0;
          if (accept) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (word_count == CNT_W'(i)) begin
                instr[(NUM_WORDS-i)*WORD_W-1 -: WORD_W]
                  <= in_word;
              end
            end
            word_count <= word_count + CNT_W'(1);
            if (finish) begin
              state <= FIRE;
              start <= 1'b1;
            end
          end
        end
        FIRE: begin
          state     <= RUN;
          start     <= 1'b0;
          load_done <= 1'b1;
        end
        RUN: begin
          start     <= 1'b0;
          load_done <= 1'b1;
        end
        default: begin
          state     <= LOAD;
          start     <= 1'b0;
          load_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven vectors plus scoreboard of accepted words
// compared slot by slot against the bundle whenever start pulses.
module tb_instr_loader;

  localparam int NW = 10;
  localparam int WW = 32;
  localparam int CW = 4;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic [WW-1:0]      in_word;
  logic               in_last;
  logic               in_ready;
  logic               reload;
  logic [NW*WW-1:0]   instr;
  logic               start;
  logic               load_done;
  logic [CW-1:0]      word_count;

  instr_loader #(
    .NUM_WORDS(NW),
    .WORD_W   (WW),
    .CNT_W    (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .reload    (reload),
    .instr     (instr),
    .start     (start),
    .load_done (load_done),
    .word_count(word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          v;
    logic [WW-1:0] w;
    logic          l;
    logic          rl;
    logic          rdy;
    logic          st;
    logic          dn;
    logic [CW-1:0] cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t          tv[NV];
  logic [WW-1:0] sb[$];
  int            n_chk;
  int            n_fail;

  function automatic vec_t mk(
    input logic v, input logic [WW-1:0] w,
    input logic l, input logic rl,
    input logic rdy, input logic st,
    input logic dn, input int cnt);
    vec_t r;
    r.v = v; r.w = w; r.l = l; r.rl = rl;
    r.rdy = rdy; r.st = st; r.dn = dn;
    r.cnt = CW'(cnt);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [NW*WW-1:0] act,
                     input logic [NW*WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_bundle(input string nm);
    logic [WW-1:0] e;
    for (int k = 0; k < NW; k++) begin
      e = (k < sb.size()) ? sb[k] : '0;
      chk($sformatf("%s slot%0d", nm, k),
          NW*WW'(instr[(NW-k)*WW-1 -: WW]), NW*WW'(e));
    end
    sb.delete();
  endtask

  task automatic step(
    input string nm,
    input logic v, input logic [WW-1:0] w,
    input logic l, input logic rl, input logic rs,
    input logic chk_rdy, input logic rdy,
    input logic st, input logic dn, input logic [CW-1:0] cnt);
    @(negedge clock);
    in_valid = v;
    in_word  = w;
    in_last  = l;
    reload   = rl;
    reset    = rs;
    #1;
    if (chk_rdy) begin
      chk({nm, " ready"}, NW*WW'(in_ready), NW*WW'(rdy));
      if (v && rdy) sb.push_back(w);
    end
    if (rl || rs) sb.delete();
    @(posedge clock);
    #1;
    chk({nm, " start"}, NW*WW'(start), NW*WW'(st));
    chk({nm, " done"}, NW*WW'(load_done), NW*WW'(dn));
    chk({nm, " count"}, NW*WW'(word_count), NW*WW'(cnt));
    if (cnt == '0) chk({nm, " instr0"}, instr, '0);
    if (start) check_bundle({nm, " bundle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    in_valid = 0; in_word = '0; in_last = 0;
    reload = 0; reset = 1;

    // three-word program, ignored word in RUN
    tv[0]  = mk(1, 32'h20010003, 0, 0, 1, 0, 0, 1);
    tv[1]  = mk(1, 32'h00211020, 0, 0, 1, 0, 0, 2);
    tv[2]  = mk(1, 32'h20430001, 1, 0, 1, 1, 0, 3);
    tv[3]  = mk(0, 32'h0,        0, 0, 0, 0, 1, 3);
    tv[4]  = mk(1, 32'hdeadbeef, 0, 0, 0, 0, 1, 3);
    // reload from RUN, single-word reprogram
    tv[5]  = mk(0, 32'h0,        0, 1, 0, 0, 0, 0);
    tv[6]  = mk(1, 32'h08000001, 1, 0, 1, 1, 0, 1);
    tv[7]  = mk(0, 32'h0,        0, 0, 0, 0, 1, 1);
    tv[8]  = mk(0, 32'h0,        0, 1, 0, 0, 0, 0);
    // in_valid toggling
    tv[9]  = mk(1, 32'h11111111, 0, 0, 1, 0, 0, 1);
    tv[10] = mk(0, 32'hffffffff, 0, 0, 1, 0, 0, 1);
    tv[11] = mk(1, 32'h22222222, 0, 0, 1, 0, 0, 2);
    tv[12] = mk(0, 32'hffffffff, 1, 0, 1, 0, 0, 2);
    tv[13] = mk(1, 32'h33333333, 0, 0, 1, 0, 0, 3);
    tv[14] = mk(0, 32'hffffffff, 0, 0, 1, 0, 0, 3);
    tv[15] = mk(1, 32'h44444444, 1, 0, 1, 1, 0, 4);
    tv[16] = mk(0, 32'h0,        0, 0, 0, 0, 1, 4);
    tv[17] = mk(0, 32'h0,        0, 1, 0, 0, 0, 0);
    // reload concurrent with a valid word
    tv[18] = mk(1, 32'haaaa0001, 0, 0, 1, 0, 0, 1);
    tv[19] = mk(1, 32'haaaa0002, 0, 0, 1, 0, 0, 2);
    tv[20] = mk(1, 32'haaaa0003, 0, 1, 0, 0, 0, 0);
    tv[21] = mk(1, 32'hbbbb0001, 1, 0, 1, 1, 0, 1);
    tv[22] = mk(0, 32'h0,        0, 0, 0, 0, 1, 1);
    // reload during FIRE skips RUN
    tv[23] = mk(0, 32'h0,        0, 1, 0, 0, 0, 0);
    tv[24] = mk(1, 32'hcccc0001, 1, 0, 1, 1, 0, 1);
    tv[25] = mk(0, 32'h0,        0, 1, 0, 0, 0, 0);
    tv[26] = mk(0, 32'h0,        0, 0, 1, 0, 0, 0);

    step("reset", 0, '0, 0, 0, 1, 0, 0, 0, 0, '0);
    step("idle", 0, '0, 0, 0, 0, 1, 1, 0, 0, '0);

    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), tv[i].v, tv[i].w,
           tv[i].l, tv[i].rl, 0, 1, tv[i].rdy,
           tv[i].st, tv[i].dn, tv[i].cnt);
    end

    // ten words without in_last: auto-fire at full
    for (int i = 1; i <= NW; i++) begin
      step($sformatf("full%0d", i), 1, WW'(i), 0, 0, 0,
           1, 1, (i == NW), 0, CW'(i));
    end
    step("full_run", 1, 32'h0000000b, 0, 0, 0,
         1, 0, 0, 1, CW'(NW));
    step("full_hold", 1, 32'h0000000b, 0, 0, 0,
         1, 0, 0, 1, CW'(NW));
    chk("full low slot", NW*WW'(instr[31:0]), NW*WW'(32'ha));
    chk("full top slot", NW*WW'(instr[319:288]), NW*WW'(32'h1));
    step("full_rl", 0, '0, 0, 1, 0, 1, 0, 0, 0, '0);

    // reset mid-load discards five words, no start follows
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("part%0d", i), 1, WW'(32'h100 + i), 0,
           0, 0, 1, 1, 0, 0, CW'(i));
    end
    step("mid_reset", 1, 32'h106, 1, 0, 1,
         0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("post_rst%0d", i), 0, '0, 0, 0, 0,
           1, 1, 0, 0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
